// File: rtl/nand2_cell_bist_if.sv
// rtl/nand2_cell_bist_if.sv - A1/A2 -> ZN connection between the BIST and the NAND2 cell under test
interface nand2_cell_bist_if;
  logic cut_a1;
  logic cut_a2;
  logic cut_zn;

  modport master (output cut_a1, output cut_a2, input cut_zn);
  modport slave  (input cut_a1, input cut_a2, output cut_zn);
endinterface

// File: rtl/nand2_cell_bist.sv
// rtl/nand2_cell_bist.sv - exhaustive 4-vector NAND2 sweep with settle-timed ZN sampling
// Accumulates a saturating mismatch count and a per-vector fail map over PASSES sweeps.
module nand2_cell_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic                  CLK,
  input  logic                  RN,
  input  logic                  start,
  nand2_cell_bist_if.master     cut,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [3:0]            fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [7:0]       LAST_PASS = 8'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic             a1_q, a1_d;
  logic             a2_q, a2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;

  logic             zn_exp;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;
  logic [1:0]       vec_nxt;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= ST_IDLE;
      vec_q      <= 2'd0;
      settle_q   <= 4'd0;
      pass_cnt_q <= 8'd0;
      a1_q       <= 1'b0;
      a2_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_d     = fail_q;

    // Case inequality so an X or Z response from the cell is counted as a failure.
    zn_exp   = ~(a1_q & a2_q);
    mismatch = (cut.cut_zn !== zn_exp);
    err_inc  = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
    vec_nxt  = vec_q + 2'd1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = '0;
          fail_d     = 4'd0;
          vec_d      = 2'd0;
          a1_d       = 1'b0;
          a2_d       = 1'b0;
          settle_d   = SETTLE_LD;
          pass_cnt_d = 8'd0;
        end
      end

      ST_RUN: begin
        if (settle_q == 4'd1) begin
          if (mismatch) begin
            err_d  = err_inc;
            fail_d = fail_q | (4'b0001 << vec_q);
          end
          if ((vec_q == 2'd3) && (pass_cnt_q == LAST_PASS)) begin
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            pass_d     = (err_d == '0);
            vec_d      = 2'd0;
            a1_d       = 1'b0;
            a2_d       = 1'b0;
            settle_d   = 4'd0;
            pass_cnt_d = 8'd0;
          end else begin
            vec_d    = vec_nxt;
            a1_d     = vec_nxt[1];
            a2_d     = vec_nxt[0];
            settle_d = SETTLE_LD;
            if (vec_q == 2'd3) begin
              pass_cnt_d = pass_cnt_q + 8'd1;
            end
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cut.cut_a1 = a1_q;
  assign cut.cut_a2 = a2_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fail_q;

endmodule
